// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, one-cycle ROM latency
// tracking, and a 2-entry {pc, instr} output queue with valid/ready to decode.
// Redirects flush the queue and the in-flight response, then restart fetch
// at the redirect target.
module fetch_unit #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [31:0]           o_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    input  logic                  i_redirect,
    input  logic [31:0]           i_redirect_pc
);

    logic [31:0]           r_req_pc;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_pc;
    logic [31:0]           r_fifo_pc    [0:1];
    logic [DATA_WIDTH-1:0] r_fifo_instr [0:1];
    logic                  r_head;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_occ;
    logic                  w_tail;
    logic [31:0]           w_target_pc;

    // Handshake, occupancy-after-this-cycle and issue decision.
    // A new request is issued only if its response is guaranteed a free slot.
    always_comb begin
        w_pop       = 1'b0;
        w_occ       = 3'd0;
        w_issue     = 1'b0;
        w_tail      = 1'b0;
        w_target_pc = i_redirect_pc & 32'hFFFF_FFFC;
        if (i_redirect) begin
            w_pop = 1'b0;
        end else begin
            w_pop = o_valid & i_ready;
        end
        w_occ   = {1'b0, r_count} + {2'b00, r_rsp_valid} - {2'b00, w_pop};
        w_issue = ~i_redirect & (w_occ <= 3'd1);
        // With two entries the tail slot equals the head slot; a push then
        // only happens together with a pop, so the old head is overwritten.
        w_tail  = r_head ^ r_count[0];
    end

    assign o_imem_addr = r_req_pc[ADDR_WIDTH+1:2];
    assign o_valid     = (r_count != 2'd0);
    assign o_pc        = r_fifo_pc[r_head];
    assign o_instr     = r_fifo_instr[r_head];

    // Request side: PC generator and response tag for the ROM's one-cycle latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_pc    <= RESET_PC;
            r_rsp_valid <= 1'b0;
            r_rsp_pc    <= 32'h0000_0000;
        end else if (i_redirect) begin
            r_req_pc    <= w_target_pc;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= w_issue;
            if (w_issue) begin
                r_rsp_pc <= r_req_pc;
                r_req_pc <= r_req_pc + 32'd4;
            end
        end
    end

    // Output queue: push the tagged ROM response, pop on a decode transfer,
    // flush everything on redirect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fifo_pc[0]    <= 32'h0000_0000;
            r_fifo_pc[1]    <= 32'h0000_0000;
            r_fifo_instr[0] <= '0;
            r_fifo_instr[1] <= '0;
            r_head          <= 1'b0;
            r_count         <= 2'd0;
        end else if (i_redirect) begin
            r_count <= 2'd0;
        end else begin
            if (r_rsp_valid) begin
                r_fifo_pc[w_tail]    <= r_rsp_pc;
                r_fifo_instr[w_tail] <= i_imem_rdata;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= w_occ[1:0];
        end
    end

    fetch_unit_chk u_chk (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_full      (r_count == 2'd2),
        .i_rsp_valid (r_rsp_valid),
        .i_pop       (w_pop),
        .i_redirect  (i_redirect)
    );

endmodule

// Queue overflow checker: a response must never arrive at a full queue
// without a simultaneous pop or flush.
module fetch_unit_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_full,
    input logic i_rsp_valid,
    input logic i_pop,
    input logic i_redirect
);

    // Flag a push into a full queue that is neither popped nor flushed.
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            a_no_overflow: assert (!(i_full && i_rsp_valid && !i_pop && !i_redirect));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes the expected {pc, instr}
// stream, a negedge monitor pops and compares on every decode transfer, and
// directed checks cover reset, latency, stall, redirect, wrap and async reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] rom [0:4095];
    logic [63:0] expq [$];
    int          n_chk;
    int          n_err;
    int          n_xfer;

    fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_addr   (imem_addr),
        .i_imem_rdata  (imem_rdata),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_valid       (o_valid),
        .i_ready       (ready),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: word n holds 0x1000_0000 + n.
    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 32'h1000_0000 + 32'(i);
    end
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected stream from a byte PC: instr is the ROM word at pc[13:2].
    task automatic push_seq(input logic [31:0] pc0, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = pc0 + 32'(4 * i);
            expq.push_back({pc, 32'h1000_0000 + ((pc >> 2) & 32'h0000_0FFF)});
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        cyc();
        @(negedge clk);
    endtask

    // Monitor: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && o_valid && ready && !redirect) begin
            n_chk++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected actual=%0h/%0h required=none", o_pc, o_instr);
            end else begin
                e = expq.pop_front();
                n_xfer++;
                if ({o_pc, o_instr} !== e) begin
                    n_err++;
                    $display("FAIL sb_stream actual=%0h/%0h required=%0h/%0h",
                             o_pc, o_instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_err = 0; n_xfer = 0;
        rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'h0);
        chk("rst_pc", 64'(o_pc), 64'h0);
        chk("rst_instr", 64'(o_instr), 64'h0);
        chk("rst_addr", 64'(imem_addr), 64'h0);

        // Reset release and streaming
        expq.delete();
        push_seq(32'h0, 64);
        cyc(); rst_n = 1'b1;              // C1
        @(negedge clk);
        chk("c1_valid", 64'(o_valid), 64'h0);
        chk("c1_addr", 64'(imem_addr), 64'h0);
        obs();                             // C2
        chk("c2_valid", 64'(o_valid), 64'h0);
        obs();                             // C3
        chk("c3_valid", 64'(o_valid), 64'h1);
        chk("c3_pc", 64'(o_pc), 64'h0);
        for (int k = 0; k < 20; k++) begin
            obs();
            chk("stream_nobubble", 64'(o_valid), 64'h1);
        end

        // Backpressure: fresh start, stall 5 cycles while 0x8 is at the head
        cyc(); rst_n = 1'b0;
        cyc(); cyc();
        expq.delete();
        push_seq(32'h0, 64);
        cyc(); rst_n = 1'b1;              // C1
        obs(); obs(); obs();              // C2..C4
        cyc(); ready = 1'b0;              // C5
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            chk("stall_valid", 64'(o_valid), 64'h1);
            chk("stall_pc", 64'(o_pc), 64'h8);
            chk("stall_instr", 64'(o_instr), 64'h1000_0002);
            if (k > 0) chk("stall_count", 64'(dut.r_count), 64'h2);
        end
        cyc(); ready = 1'b1;              // C10
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("release_nobubble", 64'(o_valid), 64'h1);
            cyc();
        end

        // Redirect with two entries queued
        ready = 1'b0;
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        expq.delete();
        push_seq(32'h100, 8);
        @(negedge clk);
        chk("redir_q_count", 64'(dut.r_count), 64'h2);
        cyc(); redirect = 1'b0; ready = 1'b1;   // t+1
        @(negedge clk);
        chk("redir_t1_valid", 64'(o_valid), 64'h0);
        obs();
        chk("redir_t2_valid", 64'(o_valid), 64'h0);
        obs();
        chk("redir_t3_valid", 64'(o_valid), 64'h1);
        chk("redir_t3_pc", 64'(o_pc), 64'h100);
        chk("redir_t3_instr", 64'(o_instr), 64'h1000_0040);
        obs(); obs();

        // Redirect in the same cycle as a handshake
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        expq.delete();
        push_seq(32'h200, 8);
        @(negedge clk);
        chk("hs_redir_valid", 64'(o_valid), 64'h1);
        cyc(); redirect = 1'b0;
        @(negedge clk);
        chk("hs_t1_valid", 64'(o_valid), 64'h0);
        obs();
        chk("hs_t2_valid", 64'(o_valid), 64'h0);
        obs();
        chk("hs_t3_pc", 64'(o_pc), 64'h200);
        obs(); obs();

        // Address wrap
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_3FF8;
        expq.delete();
        push_seq(32'h3FF8, 8);
        cyc(); redirect = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", 64'(imem_addr), 64'hFFE);
        obs();
        chk("wrap_addr1", 64'(imem_addr), 64'hFFF);
        obs();
        chk("wrap_addr2", 64'(imem_addr), 64'h000);
        chk("wrap_pc", 64'(o_pc), 64'h3FF8);
        for (int k = 0; k < 4; k++) obs();

        // Async reset between clock edges
        chk("areset_pre_valid", 64'(o_valid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid", 64'(o_valid), 64'h0);
        expq.delete();
        push_seq(32'h0, 16);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;                  // C1
        @(negedge clk);
        chk("ar_c1_valid", 64'(o_valid), 64'h0);
        obs();
        chk("ar_c2_valid", 64'(o_valid), 64'h0);
        obs();
        chk("ar_c3_valid", 64'(o_valid), 64'h1);
        chk("ar_c3_pc", 64'(o_pc), 64'h0);
        for (int k = 0; k < 4; k++) obs();

        chk("xfer_total_min", 64'(n_xfer > 30), 64'h1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
